// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and data_memory: decodes the request,
// checks legality, strobes memory for one cycle and returns data or an exception.
module load_store_unit #(
  parameter int DMEM_BYTES = 256,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  input  logic              flush,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_mask,
  output logic              mem_rd_en,
  output logic              mem_wr_en_n,
  output logic              mem_cs_n,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_load_data,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_tval
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] DMEM_LIMIT = ADDR_W'(DMEM_BYTES);

  state_t state_reg, state_next;

  logic              accept;
  logic              dec_illegal, dec_misaligned, dec_fault, dec_exc;
  logic [3:0]        dec_mask, dec_cause;
  logic [31:0]       dec_wdata, dec_tval;

  logic              load_reg, store_reg, exc_reg, kill_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg, load_data_reg, tval_reg;
  logic [3:0]        mask_reg, cause_reg;
  logic              mem_en, deliver;

  assign accept = (state_reg == IDLE) && req_valid && !flush;

  // Request decode: mask encoding, lane replication and exception priority
  always_comb begin
    dec_mask  = 4'b0000;
    dec_wdata = {4{req_wdata[7:0]}};
    case (req_funct3)
      3'b001: begin
        dec_mask  = 4'b0001;
        dec_wdata = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        dec_mask  = 4'b1000;
        dec_wdata = req_wdata;
      end
      3'b100: dec_mask = 4'b0010;
      3'b101: dec_mask = 4'b0100;
      default: dec_mask = 4'b0000;
    endcase

    dec_illegal    = (req_load == req_store)
                   || (req_load && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11))
                   || (req_store && req_funct3 >= 3'b011);
    dec_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0])
                   || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    dec_fault      = req_addr >= DMEM_LIMIT;
    dec_exc        = dec_illegal || dec_misaligned || dec_fault;

    dec_cause = 4'd0;
    dec_tval  = 32'd0;
    if (dec_illegal) begin
      dec_cause = 4'd2;
    end else if (dec_misaligned) begin
      dec_cause = req_load ? 4'd4 : 4'd6;
      dec_tval  = 32'(req_addr);
    end else if (dec_fault) begin
      dec_cause = req_load ? 4'd5 : 4'd7;
      dec_tval  = 32'(req_addr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_reg      <= 1'b0;
      store_reg     <= 1'b0;
      exc_reg       <= 1'b0;
      kill_reg      <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      mask_reg      <= 4'd0;
      cause_reg     <= 4'd0;
      tval_reg      <= 32'd0;
      load_data_reg <= 32'd0;
    end else begin
      if (accept) begin
        load_reg      <= req_load;
        store_reg     <= req_store;
        exc_reg       <= dec_exc;
        kill_reg      <= 1'b0;
        addr_reg      <= req_addr;
        wdata_reg     <= req_store ? dec_wdata : 32'd0;
        mask_reg      <= dec_mask;
        cause_reg     <= dec_cause;
        tval_reg      <= dec_tval;
        load_data_reg <= 32'd0;
      end
      if (state_reg == ACCESS) begin
        if (flush) begin
          kill_reg <= 1'b1;
        end
        load_data_reg <= (load_reg && !exc_reg) ? mem_rdata : 32'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Faulting requests still pass through ACCESS (strobes quiet) so every
  // response, good or bad, lands two cycles after acceptance.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_reg == IDLE);
    busy        = (state_reg != IDLE);
    mem_en      = (state_reg == ACCESS) && !exc_reg;
    mem_cs_n    = !mem_en;
    mem_rd_en   = mem_en && load_reg;
    mem_wr_en_n = !(mem_en && store_reg);
    mem_addr    = mem_en ? 32'(addr_reg) : 32'd0;
    mem_wdata   = mem_en ? wdata_reg : 32'd0;
    mem_mask    = mem_en ? mask_reg : 4'd0;
    deliver     = (state_reg == RESP) && !kill_reg && !flush;
    resp_valid  = deliver && !exc_reg;
    exc_valid   = deliver && exc_reg;
    resp_load_data = load_data_reg;
    exc_cause   = cause_reg;
    exc_tval    = tval_reg;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, reference memory and a
// response scoreboard with latency tracking.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, flush = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, busy, mem_rd_en, mem_wr_en_n, mem_cs_n, resp_valid, exc_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_load_data, exc_tval;
  logic [3:0]  mem_mask, exc_cause;

  load_store_unit #(.DMEM_BYTES(256), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .flush(flush),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rd_en(mem_rd_en), .mem_wr_en_n(mem_wr_en_n), .mem_cs_n(mem_cs_n),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_load_data(resp_load_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [31:0] data;
    logic [3:0]  cause;
    logic [31:0] tval;
    int          due;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0, n_bad = 0, cyc = 0;
  logic [7:0] dmem    [256];
  logic [7:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // data_memory stand-in: sign/zero-extends on read, writes the addressed lane on negedge
  logic [7:0] ma;
  always_comb begin
    ma = mem_addr[7:0];
    case (mem_mask)
      4'b0000: mem_rdata = {{24{dmem[ma][7]}}, dmem[ma]};
      4'b0010: mem_rdata = {24'd0, dmem[ma]};
      4'b0001: mem_rdata = {{16{dmem[ma+8'd1][7]}}, dmem[ma+8'd1], dmem[ma]};
      4'b0100: mem_rdata = {16'd0, dmem[ma+8'd1], dmem[ma]};
      4'b1000: mem_rdata = {dmem[ma+8'd3], dmem[ma+8'd2], dmem[ma+8'd1], dmem[ma]};
      default: mem_rdata = 32'hxxxxxxxx;
    endcase
  end

  always @(negedge clk) begin
    if (!mem_cs_n && !mem_wr_en_n) begin
      case (mem_mask)
        4'b0000: dmem[ma] <= mem_wdata[8*ma[1:0] +: 8];
        4'b0001: begin
          dmem[ma]       <= mem_wdata[16*ma[1] +: 8];
          dmem[ma+8'd1]  <= mem_wdata[16*ma[1]+8 +: 8];
        end
        default: begin
          dmem[ma]      <= mem_wdata[7:0];
          dmem[ma+8'd1] <= mem_wdata[15:8];
          dmem[ma+8'd2] <= mem_wdata[23:16];
          dmem[ma+8'd3] <= mem_wdata[31:24];
        end
      endcase
    end
  end

  // Response monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid || exc_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_resp", {31'd0, resp_valid | exc_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_kind", {30'd0, exc_valid, resp_valid}, e.exc ? 32'd2 : 32'd1);
        check("latency", 32'(cyc), 32'(e.due));
        if (e.exc) begin
          check("exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
          check("exc_tval", exc_tval, e.tval);
        end else begin
          check("load_data", resp_load_data, e.data);
        end
      end
    end
  end

  // flush_mode: 0 none, 1 during ACCESS, 2 during RESP
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int flush_mode);
    logic        illegal, misal, fault, legal;
    logic [3:0]  e_mask, e_cause;
    logic [31:0] e_wd, e_data, e_tval;
    logic [7:0]  a, b0, b1, b2, b3;
    exp_t        e;
    int          k;

    illegal = (ld && st) || (!ld && !st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 >= 3);
    misal   = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    fault   = addr >= 32'd256;
    legal   = !(illegal || misal || fault);
    e_cause = illegal ? 4'd2 : misal ? (ld ? 4'd4 : 4'd6) : (ld ? 4'd5 : 4'd7);
    e_tval  = illegal ? 32'd0 : addr;
    case (f3)
      3'd0: e_mask = 4'b0000;
      3'd1: e_mask = 4'b0001;
      3'd2: e_mask = 4'b1000;
      3'd4: e_mask = 4'b0010;
      default: e_mask = 4'b0100;
    endcase
    case (f3)
      3'd0: e_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'd1: e_wd = {wd[15:0], wd[15:0]};
      default: e_wd = wd;
    endcase
    a  = addr[7:0];
    b0 = ref_mem[a]; b1 = ref_mem[a+8'd1]; b2 = ref_mem[a+8'd2]; b3 = ref_mem[a+8'd3];
    case (f3)
      3'd0: e_data = {{24{b0[7]}}, b0};
      3'd1: e_data = {{16{b1[7]}}, b1, b0};
      3'd4: e_data = {24'd0, b0};
      3'd5: e_data = {16'd0, b1, b0};
      default: e_data = {b3, b2, b1, b0};
    endcase
    if (st) e_data = 32'd0;

    @(posedge clk); #1;
    k = 0;
    while (!req_ready && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_access", {31'd0, busy}, 32'd1);
    if (legal) begin
      check("mem_cs_n", {31'd0, mem_cs_n}, 32'd0);
      check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, ld});
      check("mem_wr_en_n", {31'd0, mem_wr_en_n}, {31'd0, !st});
      check("mem_mask", {28'd0, mem_mask}, {28'd0, e_mask});
      check("mem_addr", mem_addr, addr);
      if (st) check("mem_wdata", mem_wdata, e_wd);
    end else begin
      check("no_strobe_cs", {31'd0, mem_cs_n}, 32'd1);
      check("no_strobe_wr", {31'd0, mem_wr_en_n}, 32'd1);
    end
    if (legal && st) begin
      ref_mem[a] = e_wd[8*a[1:0] +: 8];
      if (f3 == 3'd1) ref_mem[a+8'd1] = e_wd[8*a[1:0]+8 +: 8];
      if (f3 == 3'd2) begin
        ref_mem[a+8'd1] = e_wd[15:8];
        ref_mem[a+8'd2] = e_wd[23:16];
        ref_mem[a+8'd3] = e_wd[31:24];
      end
    end
    if (flush_mode == 0) begin
      e.exc = !legal; e.data = e_data; e.cause = e_cause; e.tval = e_tval; e.due = cyc + 1;
      sb_q.push_back(e);
    end
    if (flush_mode == 1) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (flush_mode == 2) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 8'd0;
      ref_mem[i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_cs_n", {31'd0, mem_cs_n}, 32'd1);
    check("rst_wr_en_n", {31'd0, mem_wr_en_n}, 32'd1);
    check("rst_resp", {30'd0, resp_valid, exc_valid}, 32'd0);
    check("rst_data", resp_load_data, 32'd0);
    check("rst_cause", {28'd0, exc_cause}, 32'd0);
    check("rst_tval", exc_tval, 32'd0);
    reset = 1'b0;

    issue(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);   // SW
    issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 0);          // LW
    issue(1'b0, 1'b1, 3'd0, 32'h13, 32'h000000A5, 0);   // SB
    issue(1'b1, 1'b0, 3'd0, 32'h13, 32'h0, 0);          // LB
    issue(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, 0);          // LBU
    issue(1'b0, 1'b1, 3'd1, 32'h22, 32'hABCD8765, 0);   // SH
    issue(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, 0);          // LH
    issue(1'b1, 1'b0, 3'd5, 32'h22, 32'h0, 0);          // LHU
    issue(1'b1, 1'b0, 3'd1, 32'h21, 32'h0, 0);          // misaligned LH
    issue(1'b0, 1'b1, 3'd2, 32'h102, 32'h1, 0);         // misaligned beats range
    issue(1'b0, 1'b1, 3'd2, 32'h100, 32'h1, 0);         // access fault
    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0);         // load access fault
    issue(1'b1, 1'b1, 3'd2, 32'h10, 32'h0, 0);          // both set
    issue(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 0);          // neither set
    issue(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, 0);          // bad load funct3
    issue(1'b0, 1'b1, 3'd4, 32'h10, 32'h0, 0);          // bad store funct3
    issue(1'b0, 1'b1, 3'd0, 32'hFF, 32'h0000005A, 0);   // last byte in range
    issue(1'b1, 1'b0, 3'd2, 32'hFC, 32'h0, 0);
    issue(1'b0, 1'b1, 3'd2, 32'h40, 32'h11223344, 1);   // flushed store still commits
    issue(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 0);
    issue(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 2);          // load flushed in RESP

    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    req_valid = 1'b0; flush = 1'b0;

    // asynchronous reset in the middle of a store ACCESS
    @(posedge clk); #1;
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_cs_n", {31'd0, mem_cs_n}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("arst_cs_n", {31'd0, mem_cs_n}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 0);          // store must not have landed

    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
